instr_decode_stage: RTL and testbench

Registered, handshaked RISC-V decode stage that supersedes the purely combinational ImmSrc decode. It classifies the opcode into a 3-bit immediate-source code that adds U type. It builds the sign-extended XLEN immediate and flags illegal opcodes. A one-entry skid buffer absorbs backpressure, so the stage sits between fetch and execute with full throughput and no combinational ready path.

---
 rtl/instr_decode_stage.sv | 138 +++++++++++++
 tb/tb_instr_decode_stage.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_stage.sv
// Registered RISC-V decode stage: immediate-source classify, sign-extended immediate,
// illegal-opcode flag and saturating counter, behind a one-entry skid buffer.
module instr_decode_stage #(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_arstn,
  input  logic             i_valid,
  output logic             o_in_ready,
  input  logic [ILEN-1:0]  i_instr,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_out_ready,
  output logic [ILEN-1:0]  o_instr,
  output logic [2:0]       o_imm_src,
  output logic [XLEN-1:0]  o_imm,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_illegal_cnt
);

  localparam logic [2:0] SRC_I = 3'b000;
  localparam logic [2:0] SRC_S = 3'b001;
  localparam logic [2:0] SRC_B = 3'b010;
  localparam logic [2:0] SRC_J = 3'b011;
  localparam logic [2:0] SRC_U = 3'b100;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [2:0]      src;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } ent_t;

  ent_t             dec;
  logic [31:0]      imm32;
  ent_t             out_q, out_d;
  ent_t             skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             out_free;

  always_comb begin
    dec       = '0;
    dec.instr = i_instr;
    imm32     = '0;
    unique case (i_instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: begin
        dec.src = SRC_I;
        imm32   = {{20{i_instr[31]}}, i_instr[31:20]};
      end
      7'b0100011: begin
        dec.src = SRC_S;
        imm32   = {{20{i_instr[31]}}, i_instr[31:25],
                   i_instr[11:7]};
      end
      7'b1100011: begin
        dec.src = SRC_B;
        imm32   = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                   i_instr[30:25], i_instr[11:8], 1'b0};
      end
      7'b1101111: begin
        dec.src = SRC_J;
        imm32   = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                   i_instr[20], i_instr[30:21], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec.src = SRC_U;
        imm32   = {i_instr[31:12], 12'b0};
      end
      7'b0110011: ;
      default: dec.illegal = 1'b1;
    endcase
    dec.imm = XLEN'($signed(imm32));
  end

  assign accept   = i_valid && in_ready_q && !i_flush;
  assign out_free = !out_valid_q || i_out_ready;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = cnt_q;
    if (accept && dec.illegal && cnt_q != '1)
      cnt_d = cnt_q + CNT_W'(1);
    if (i_flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      // SKID can only be full here with no accept, since ready is low
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) out_d = dec;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      cnt_q        <= '0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      cnt_q        <= cnt_d;
    end
  end

  assign o_in_ready    = in_ready_q;
  assign o_valid       = out_valid_q;
  assign o_instr       = out_q.instr;
  assign o_imm_src     = out_q.src;
  assign o_imm         = out_q.imm;
  assign o_illegal     = out_q.illegal;
  assign o_illegal_cnt = cnt_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage: reset, stream, backpressure,
// illegal counting/saturation, flush and asynchronous reset.
module tb_instr_decode_stage;

  typedef struct packed {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [31:0] imm;
    logic        illegal;
  } exp_t;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        valid = 0;
  logic [31:0] instr = '0;
  logic        flush = 0;
  logic        out_ready = 0;
  logic        in_ready, o_valid, o_illegal;
  logic [31:0] o_instr, o_imm;
  logic [2:0]  o_src;
  logic [7:0]  cnt;
  logic        s_in_ready, s_valid, s_illegal;
  logic [31:0] s_instr, s_imm;
  logic [2:0]  s_src;
  logic [1:0]  s_cnt;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  instr_decode_stage u_dut (
    .i_clk(clk), .i_arstn(rst_n), .i_valid(valid),
    .o_in_ready(in_ready), .i_instr(instr), .i_flush(flush),
    .o_valid(o_valid), .i_out_ready(out_ready),
    .o_instr(o_instr), .o_imm_src(o_src), .o_imm(o_imm),
    .o_illegal(o_illegal), .o_illegal_cnt(cnt)
  );

  instr_decode_stage #(.CNT_W(2)) u_sat (
    .i_clk(clk), .i_arstn(rst_n), .i_valid(valid),
    .o_in_ready(s_in_ready), .i_instr(instr), .i_flush(flush),
    .o_valid(s_valid), .i_out_ready(out_ready),
    .o_instr(s_instr), .o_imm_src(s_src), .o_imm(s_imm),
    .o_illegal(s_illegal), .o_illegal_cnt(s_cnt)
  );

  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    logic s;
    s = w[31];
    e = '0;
    e.instr = w;
    if (w[6:0] == 7'h03 || w[6:0] == 7'h13 || w[6:0] == 7'h67) begin
      e.imm = {{20{s}}, w[31:20]};
    end else if (w[6:0] == 7'h23) begin
      e.src = 3'd1;
      e.imm = {{20{s}}, w[31:25], w[11:7]};
    end else if (w[6:0] == 7'h63) begin
      e.src = 3'd2;
      e.imm = {{20{s}}, w[7], w[30:25], w[11:8], 1'b0};
    end else if (w[6:0] == 7'h6F) begin
      e.src = 3'd3;
      e.imm = {{12{s}}, w[19:12], w[20], w[30:21], 1'b0};
    end else if (w[6:0] == 7'h37 || w[6:0] == 7'h17) begin
      e.src = 3'd4;
      e.imm = {w[31:12], 12'h000};
    end else if (w[6:0] != 7'h33) begin
      e.illegal = 1'b1;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && o_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got instr %h, none expected", o_instr);
      end else begin
        e = sb.pop_front();
        if ({o_instr, o_src, o_imm, o_illegal} !== e) begin
          errors++;
          $display("FAIL sb_data: got %h/%b/%h/%b want %h/%b/%h/%b",
                   o_instr, o_src, o_imm, o_illegal,
                   e.instr, e.src, e.imm, e.illegal);
        end
      end
    end
    if (!rst_n || flush) sb.delete();
    if (rst_n && valid && in_ready && !flush) sb.push_back(model(instr));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    step();
    step();
    checks++;
    if ({o_valid, in_ready, o_instr, o_src, o_imm, o_illegal, cnt}
        !== {1'b0, 1'b1, 32'h0, 3'b0, 32'h0, 1'b0, 8'h0}) begin
      errors++;
      $display("FAIL reset: valid=%b rdy=%b instr=%h imm=%h cnt=%0d",
               o_valid, in_ready, o_instr, o_imm, cnt);
    end
    rst_n = 1;
    step();
  endtask

  task automatic test_addi();
    out_ready = 1;
    valid = 1;
    instr = 32'hFFF00093;
    step();
    valid = 0;
    checks++;
    if ({o_valid, o_src, o_imm, o_illegal} !== {1'b1, 3'b000, 32'hFFFFFFFF, 1'b0}) begin
      errors++;
      $display("FAIL addi: valid=%b src=%b imm=%h ill=%b want 1/000/ffffffff/0",
               o_valid, o_src, o_imm, o_illegal);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [4];
    logic [2:0]  src [4];
    logic [31:0] imm [4];
    ins = '{32'h00112623, 32'hFE000EE3, 32'h008000EF, 32'h123452B7};
    src = '{3'b001, 3'b010, 3'b011, 3'b100};
    imm = '{32'h0000000C, 32'hFFFFFFFC, 32'h00000008, 32'h12345000};
    out_ready = 1;
    valid = 1;
    instr = ins[0];
    for (int i = 0; i < 4; i++) begin
      step();
      if (i < 3) instr = ins[i+1];
      else valid = 0;
      checks++;
      if ({o_valid, in_ready, o_src, o_imm} !== {1'b1, 1'b1, src[i], imm[i]}) begin
        errors++;
        $display("FAIL b2b[%0d]: valid=%b rdy=%b src=%b imm=%h want 1/1/%b/%h",
                 i, o_valid, in_ready, o_src, o_imm, src[i], imm[i]);
      end
    end
    step();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: valid=%b want 0", o_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    valid = 1;
    instr = 32'h00500093;
    step();
    checks++;
    if ({o_valid, in_ready, o_instr} !== {1'b1, 1'b1, 32'h00500093}) begin
      errors++;
      $display("FAIL bp_first: valid=%b rdy=%b instr=%h", o_valid, in_ready, o_instr);
    end
    instr = 32'h00112623;
    step();
    valid = 0;
    step();
    checks++;
    if ({o_valid, in_ready, o_instr, o_imm} !== {1'b1, 1'b0, 32'h00500093, 32'h5}) begin
      errors++;
      $display("FAIL bp_hold: valid=%b rdy=%b instr=%h imm=%h want 1/0/00500093/5",
               o_valid, in_ready, o_instr, o_imm);
    end
    out_ready = 1;
    step();
    checks++;
    if ({o_valid, in_ready, o_instr} !== {1'b1, 1'b1, 32'h00112623}) begin
      errors++;
      $display("FAIL bp_release: valid=%b rdy=%b instr=%h want 1/1/00112623",
               o_valid, in_ready, o_instr);
    end
    step();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: valid=%b want 0", o_valid);
    end
  endtask

  task automatic test_illegal();
    out_ready = 1;
    valid = 1;
    instr = 32'h0000007F;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({o_valid, o_illegal, o_src, o_imm} !== {1'b1, 1'b1, 3'b0, 32'h0}) begin
        errors++;
        $display("FAIL illegal[%0d]: valid=%b ill=%b src=%b imm=%h",
                 i, o_valid, o_illegal, o_src, o_imm);
      end
    end
    valid = 0;
    step();
    checks++;
    if ({cnt, s_cnt} !== {8'd3, 2'd3}) begin
      errors++;
      $display("FAIL illegal_cnt3: cnt=%0d sat=%0d want 3/3", cnt, s_cnt);
    end
    valid = 1;
    step();
    step();
    valid = 0;
    step();
    checks++;
    if ({cnt, s_cnt} !== {8'd5, 2'd3}) begin
      errors++;
      $display("FAIL illegal_sat: cnt=%0d sat=%0d want 5/3", cnt, s_cnt);
    end
  endtask

  task automatic test_flush();
    out_ready = 0;
    valid = 1;
    instr = 32'h00A00093;
    step();
    instr = 32'h0140006F;
    step();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_full: rdy=%b want 0", in_ready);
    end
    flush = 1;
    instr = 32'h0000007F;
    step();
    flush = 0;
    valid = 0;
    checks++;
    if ({o_valid, in_ready, cnt} !== {1'b0, 1'b1, 8'd5}) begin
      errors++;
      $display("FAIL flush_full_clear: valid=%b rdy=%b cnt=%0d want 0/1/5",
               o_valid, in_ready, cnt);
    end
    valid = 1;
    instr = 32'h00300093;
    step();
    flush = 1;
    instr = 32'h0000007F;
    step();
    flush = 0;
    valid = 0;
    out_ready = 1;
    step();
    checks++;
    if ({o_valid, in_ready, cnt} !== {1'b0, 1'b1, 8'd5}) begin
      errors++;
      $display("FAIL flush_ready: valid=%b rdy=%b cnt=%0d want 0/1/5",
               o_valid, in_ready, cnt);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1;
    valid = 1;
    instr = 32'h0000007F;
    step();
    step();
    #2;
    rst_n = 0;
    #1;
    checks++;
    if ({o_valid, in_ready, cnt} !== {1'b0, 1'b1, 8'd0}) begin
      errors++;
      $display("FAIL async_reset: valid=%b rdy=%b cnt=%0d want 0/1/0",
               o_valid, in_ready, cnt);
    end
    valid = 0;
    step();
    rst_n = 1;
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d entries remain, want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
